// File: rtl/pcie_rst_seq_gen.sv
// PCIe-side reset and receive-ready sequencer.
// Each reset episode holds pcie_rst_n low, waits out a guard interval, and
// then enables pcie_tready. In RUN, pcie_tready can be throttled by an LFSR
// pattern. force_ena overrides pcie_tready in every state.
// All outputs are registered from next-state values, so no input reaches an
// output combinationally.
module pcie_rst_seq_gen #(
    parameter int          RST_HOLD_CYC = 16,
    parameter int          GUARD_CYC    = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_rst_req,
    input  logic       force_ena,
    input  logic       force_val,
    input  logic       thr_en,
    input  logic [3:0] thr_pct,
    output logic       pcie_rst_n,
    output logic       pcie_tready,
    output logic       rst_busy,
    output logic [7:0] rst_cnt
);

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_GUARD  = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Counters are loaded with N-1 and the state moves on when the count
    // reaches zero, so an N-cycle phase lasts exactly N edges.
    localparam logic [7:0]  HOLD_LD   = 8'(RST_HOLD_CYC - 1);
    localparam logic [7:0]  GUARD_LD  = 8'(GUARD_CYC - 1);
    // Right-shift Galois taps for x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  rst_cnt_q, rst_cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        rst_n_d, tready_d, busy_d;
    logic        pcie_rst_n_q, pcie_tready_q, rst_busy_q;

    // Next-state, counter, LFSR and next-output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rst_cnt_d = rst_cnt_q;
        lfsr_d    = lfsr_q;
        tready_d  = 1'b0;

        case (state_q)
            ST_ASSERT: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_GUARD;
                    cnt_d   = GUARD_LD;
                    if (rst_cnt_q != 8'hFF)
                        rst_cnt_d = rst_cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_GUARD: begin
                if (cnt_q == 8'd0)
                    state_d = ST_RUN;
                else
                    cnt_d = cnt_q - 8'd1;
            end
            ST_RUN: begin
                // A software request is honoured only from RUN, so an
                // episode already in progress is never restarted or extended.
                if (sw_rst_req) begin
                    state_d = ST_ASSERT;
                    cnt_d   = HOLD_LD;
                end
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = HOLD_LD;
            end
        endcase

        // The throttle pattern advances only while running. It is not
        // reseeded by software reset.
        if (state_q == ST_RUN)
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & LFSR_TAPS);

        if (force_ena)
            tready_d = force_val;
        else if (state_d != ST_RUN)
            tready_d = 1'b0;
        else if (!thr_en || (thr_pct == 4'd0))
            tready_d = 1'b1;
        else
            tready_d = (lfsr_q[3:0] >= thr_pct);

        rst_n_d = (state_d != ST_ASSERT);
        busy_d  = (state_d != ST_RUN);
    end

    // State, counters, LFSR and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ASSERT;
            cnt_q         <= HOLD_LD;
            rst_cnt_q     <= 8'd0;
            lfsr_q        <= LFSR_SEED;
            pcie_rst_n_q  <= 1'b0;
            pcie_tready_q <= 1'b0;
            rst_busy_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rst_cnt_q     <= rst_cnt_d;
            lfsr_q        <= lfsr_d;
            pcie_rst_n_q  <= rst_n_d;
            pcie_tready_q <= tready_d;
            rst_busy_q    <= busy_d;
        end
    end

    assign pcie_rst_n  = pcie_rst_n_q;
    assign pcie_tready = pcie_tready_q;
    assign rst_busy    = rst_busy_q;
    assign rst_cnt     = rst_cnt_q;

endmodule
